// File: rtl/accel_cmd_ctrl.sv
// accel_cmd_ctrl: host command controller for the matmul array.
// Routes host accesses to scratchpad, config regs or array start.
module accel_cmd_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SP_AW  = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              sc_read_en,
  output logic              sc_write_en,
  output logic [SP_AW-1:0]  sc_addr,
  output logic [DATA_W-1:0] sc_wdata,
  input  logic [DATA_W-1:0] sc_rdata,
  input  logic              sc_ready,
  output logic              start_matmul,
  output logic [DATA_W-1:0] input_addr,
  output logic [DATA_W-1:0] weight_addr,
  output logic [DATA_W-1:0] output_addr,
  input  logic              matmul_finished,
  output logic              busy
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SP_RD, SP_WR, RD_RESP, WR_RESP
  } state_t;

  typedef enum logic [1:0] {
    RGN_SP, RGN_CFG, RGN_START, RGN_UNM
  } rgn_t;

  function automatic rgn_t decode(
    input logic [ADDR_W-1:0] a
  );
    rgn_t r;
    r = RGN_UNM;
    unique case (1'b1)
      (a[23:20] == 4'h0) && (a[19:16] != 4'hF):
        r = RGN_SP;
      (a[23:16] == 8'h0F):
        r = RGN_CFG;
      (a[23:20] == 4'h1):
        r = RGN_START;
      (a[23:20] > 4'h1):
        r = RGN_UNM;
    endcase
    return r;
  endfunction

  state_t state;
  logic   wr_turn;
  logic   done;
  logic   idle;
  logic   rd_req;
  logic   wr_req;
  logic   rd_go;
  logic   wr_go;
  rgn_t   ar_rgn;
  rgn_t   aw_rgn;
  logic [DATA_W-1:0] status;
  logic   unused_addr;

  assign idle   = (state == IDLE);
  assign rd_req = arvalid;
  assign wr_req = awvalid & wvalid;
  assign rd_go  = idle & rd_req & (~wr_req | ~wr_turn);
  assign wr_go  = idle & wr_req & (~rd_req | wr_turn);

  assign arready = rd_go;
  assign awready = wr_go;
  assign wready  = wr_go;

  assign ar_rgn = decode(araddr);
  assign aw_rgn = decode(awaddr);
  assign status = {{(DATA_W-2){1'b0}}, done, busy};
  assign unused_addr = ^{araddr, awaddr};

  // Request arbitration, access execution and response handshakes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      wr_turn      <= 1'b0;
      bvalid       <= 1'b0;
      bresp        <= OKAY;
      rvalid       <= 1'b0;
      rdata        <= '0;
      rresp        <= OKAY;
      sc_read_en   <= 1'b0;
      sc_write_en  <= 1'b0;
      sc_addr      <= '0;
      sc_wdata     <= '0;
      start_matmul <= 1'b0;
      input_addr   <= '0;
      weight_addr  <= '0;
      output_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_matmul <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_go) begin
            if (wr_req) wr_turn <= 1'b1;
            unique case (ar_rgn)
              RGN_SP: begin
                sc_read_en <= 1'b1;
                sc_addr    <= araddr[SP_AW-1:0];
                state      <= SP_RD;
              end
              RGN_CFG: begin
                rvalid <= 1'b1;
                rresp  <= OKAY;
                state  <= RD_RESP;
                case (araddr[3:0])
                  4'h0: rdata <= input_addr;
                  4'h4: rdata <= weight_addr;
                  4'h8: rdata <= output_addr;
                  4'hC: begin
                    rdata <= status;
                    done  <= 1'b0;
                  end
                  default: begin
                    rdata <= '0;
                    rresp <= SLVERR;
                  end
                endcase
              end
              default: begin
                rvalid <= 1'b1;
                rdata  <= '0;
                rresp  <= SLVERR;
                state  <= RD_RESP;
              end
            endcase
          end else if (wr_go) begin
            if (rd_req) wr_turn <= 1'b0;
            unique case (aw_rgn)
              RGN_SP: begin
                sc_write_en <= 1'b1;
                sc_addr     <= awaddr[SP_AW-1:0];
                sc_wdata    <= wdata;
                state       <= SP_WR;
              end
              RGN_CFG: begin
                bvalid <= 1'b1;
                bresp  <= SLVERR;
                state  <= WR_RESP;
                if (!busy) begin
                  case (awaddr[3:0])
                    4'h0: begin
                      input_addr <= wdata;
                      bresp      <= OKAY;
                    end
                    4'h4: begin
                      weight_addr <= wdata;
                      bresp       <= OKAY;
                    end
                    4'h8: begin
                      output_addr <= wdata;
                      bresp       <= OKAY;
                    end
                    default: bresp <= SLVERR;
                  endcase
                end
              end
              RGN_START: begin
                bvalid <= 1'b1;
                state  <= WR_RESP;
                if (!busy) begin
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  start_matmul <= 1'b1;
                  bresp        <= OKAY;
                end else begin
                  bresp <= SLVERR;
                end
              end
              default: begin
                bvalid <= 1'b1;
                bresp  <= SLVERR;
                state  <= WR_RESP;
              end
            endcase
          end
        end
        SP_RD: begin
          if (sc_ready) begin
            sc_read_en <= 1'b0;
            rdata      <= sc_rdata;
            rresp      <= OKAY;
            rvalid     <= 1'b1;
            state      <= RD_RESP;
          end
        end
        SP_WR: begin
          if (sc_ready) begin
            sc_write_en <= 1'b0;
            bresp       <= OKAY;
            bvalid      <= 1'b1;
            state       <= WR_RESP;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (busy && matmul_finished) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_cmd_ctrl.sv
// tb_accel_cmd_ctrl: randomized bench for accel_cmd_ctrl against
// a transaction-level model of the register map and scratchpad.
module tb_accel_cmd_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        sc_read_en, sc_write_en;
  logic [15:0] sc_addr;
  logic [31:0] sc_wdata;
  logic [31:0] sc_rdata = '0;
  logic        sc_ready = 1'b0;
  logic        start_matmul;
  logic [31:0] input_addr, weight_addr, output_addr;
  logic        matmul_finished;
  logic        busy;

  accel_cmd_ctrl dut (
    .clk(clk), .n_rst(n_rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp),
    .sc_read_en(sc_read_en), .sc_write_en(sc_write_en),
    .sc_addr(sc_addr), .sc_wdata(sc_wdata),
    .sc_rdata(sc_rdata), .sc_ready(sc_ready),
    .start_matmul(start_matmul),
    .input_addr(input_addr), .weight_addr(weight_addr),
    .output_addr(output_addr),
    .matmul_finished(matmul_finished), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int sp_delay = 0;
  int en_cnt = 0;
  int last_cnt = 0;
  int sp_unstable = 0;
  int both_cnt = 0;
  int start_hi = 0;
  logic [15:0] hold_a = '0;
  logic [31:0] hold_d = '0;
  logic [15:0] wr_a_seen = '0;
  logic [31:0] wr_d_seen = '0;
  logic [31:0] sp_mem [16];

  logic [31:0] m_cfg [3];
  logic [31:0] m_mem [int];
  bit m_busy, m_done, m_wr_turn;
  int m_pulses = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scratchpad: ready after sp_delay extra cycles of enable
  always @(negedge clk) begin
    if (sc_read_en || sc_write_en) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt == 0) begin
        hold_a <= sc_addr;
        hold_d <= sc_wdata;
      end else if (sc_addr != hold_a ||
                   (sc_write_en && sc_wdata != hold_d)) begin
        sp_unstable <= sp_unstable + 1;
      end
      if (sc_read_en && sc_write_en) both_cnt <= both_cnt + 1;
      sc_rdata <= sp_mem[sc_addr[5:2]];
      if (en_cnt >= sp_delay) begin
        sc_ready <= 1'b1;
        last_cnt <= en_cnt + 1;
      end else begin
        sc_ready <= 1'b0;
      end
    end else begin
      en_cnt   <= 0;
      sc_ready <= 1'b0;
    end
  end

  // scratchpad storage, updated on the write handshake
  always @(posedge clk) begin
    if (sc_write_en && sc_ready) begin
      sp_mem[sc_addr[5:2]] <= sc_wdata;
      wr_a_seen <= sc_addr;
      wr_d_seen <= sc_wdata;
    end
  end

  // count cycles start_matmul is high
  always @(negedge clk) begin
    if (start_matmul) start_hi <= start_hi + 1;
  end

  // 0 scratchpad, 1 config, 2 start, 3 unmapped
  function automatic int region(input logic [31:0] a);
    int mid;
    mid = int'(a[23:16]);
    if (mid < 15) return 0;
    if (mid == 15) return 1;
    if (mid < 32) return 2;
    return 3;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_cfg[i] = '0;
    m_busy = 0;
    m_done = 0;
    m_wr_turn = 0;
  endfunction

  function automatic void model_read(input logic [31:0] a,
                                     output logic [31:0] d,
                                     output logic [1:0] r);
    int g;
    int off;
    int k;
    g = region(a);
    off = int'(a[3:0]);
    k = int'(a[15:0]);
    d = '0;
    r = 2'b10;
    if (g == 0) begin
      d = m_mem.exists(k) ? m_mem[k] : '0;
      r = 2'b00;
    end else if (g == 1) begin
      if (off < 12 && off % 4 == 0) begin
        d = m_cfg[off/4];
        r = 2'b00;
      end else if (off == 12) begin
        d = 32'(m_busy) + 32'(m_done) * 2;
        m_done = 0;
        r = 2'b00;
      end
    end
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [31:0] d,
                                      output logic [1:0] r,
                                      output bit p);
    int g;
    int off;
    g = region(a);
    off = int'(a[3:0]);
    r = 2'b10;
    p = 0;
    if (g == 0) begin
      m_mem[int'(a[15:0])] = d;
      r = 2'b00;
    end else if (g == 1) begin
      if (off < 12 && off % 4 == 0 && !m_busy) begin
        m_cfg[off/4] = d;
        r = 2'b00;
      end
    end else if (g == 2) begin
      if (!m_busy) begin
        m_busy = 1;
        m_done = 0;
        m_pulses++;
        p = 1;
        r = 2'b00;
      end
    end
  endfunction

  task automatic check_regs();
    chk("input_addr", input_addr, m_cfg[0]);
    chk("weight_addr", weight_addr, m_cfg[1]);
    chk("output_addr", output_addr, m_cfg[2]);
    chk("busy", busy, m_busy);
  endtask

  task automatic serve_rd(input logic [31:0] a);
    logic [31:0] ed;
    logic [1:0] er;
    bit got;
    model_read(a, ed, er);
    @(posedge clk);
    #1 arvalid = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rvalid) begin
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        rready = ($urandom_range(0, 2) != 0);
        if (rready) begin
          @(posedge clk);
          #1 rready = 1'b0;
          got = 1;
        end
      end
    end
    if (!got) chk("rvalid_timeout", 0, 1);
    if (region(a) == 0) chk("sc_rd_cycles", last_cnt, sp_delay + 1);
  endtask

  task automatic serve_wr(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] er;
    bit ep;
    bit got;
    model_write(a, d, er, ep);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid = 1'b0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (i == 0) chk("start_pulse", start_matmul, ep);
      if (bvalid) begin
        chk("bresp", bresp, er);
        bready = ($urandom_range(0, 2) != 0);
        if (bready) begin
          @(posedge clk);
          #1 bready = 1'b0;
          got = 1;
        end
      end
    end
    if (!got) chk("bvalid_timeout", 0, 1);
    if (region(a) == 0) begin
      chk("sc_wr_cycles", last_cnt, sp_delay + 1);
      chk("sc_addr", wr_a_seen, a[15:0]);
      chk("sc_wdata", wr_d_seen, d);
    end
  endtask

  task automatic xact(input bit rd, input bit wr,
                      input logic [31:0] ra, input logic [31:0] wa,
                      input logic [31:0] wd);
    bit rp, wp, cont;
    int g;
    rp = rd;
    wp = wr;
    cont = rd && wr;
    @(negedge clk);
    arvalid = rd;
    araddr = ra;
    awvalid = wr;
    wvalid = wr;
    awaddr = wa;
    wdata = wd;
    while (rp || wp) begin
      g = 0;
      #1;
      while (!arready && !awready && g < 50) begin
        @(negedge clk);
        #1;
        g++;
      end
      if (g >= 50) begin
        chk("grant_timeout", 0, 1);
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid = 1'b0;
        return;
      end
      if (cont) begin
        chk("grant_rd_first", arready, !m_wr_turn);
        m_wr_turn = !m_wr_turn;
        cont = 0;
      end
      if (arready) begin
        serve_rd(ra);
        rp = 0;
      end else begin
        serve_wr(wa, wd);
        wp = 0;
      end
    end
    check_regs();
  endtask

  task automatic finish_pulse();
    @(negedge clk);
    matmul_finished = 1'b1;
    if (m_busy) begin
      m_busy = 0;
      m_done = 1;
    end
    @(negedge clk);
    matmul_finished = 1'b0;
    chk("busy_after_fin", busy, m_busy);
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] a;
    int k;
    a = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) begin
      a[23:16] = {4'h0, 4'($urandom_range(0, 14))};
      a[15:0] = 16'($urandom_range(0, 15) * 4);
    end else if (k < 7) begin
      a[23:16] = 8'h0F;
      if ($urandom_range(0, 1) == 1)
        a[3:0] = 4'($urandom_range(0, 3) * 4);
    end else if (k < 8) begin
      a[23:20] = 4'h1;
    end else begin
      a[23:20] = 4'($urandom_range(2, 15));
    end
    return a;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int op;
    n_rst = 1'b0;
    awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0;
    bready = 0; arvalid = 0; araddr = '0; rready = 0;
    matmul_finished = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_sc_rd", sc_read_en, 0);
    chk("rst_sc_wr", sc_write_en, 0);
    chk("rst_start", start_matmul, 0);
    check_regs();
    n_rst = 1'b1;

    sp_delay = 1;
    xact(0, 1, '0, 32'h000F_0004, 32'h1234);
    chk("weight_1234", weight_addr, 32'h1234);
    xact(1, 0, 32'h000F_0004, '0, '0);

    sp_delay = 3;
    xact(0, 1, '0, 32'h0000_0010, 32'hAB);

    for (int i = 0; i < 16; i++) begin
      sp_delay = $urandom_range(0, 4);
      a = 32'(i * 4);
      a[19:16] = 4'($urandom_range(0, 14));
      xact(0, 1, '0, a, $urandom);
    end

    xact(0, 1, '0, 32'h0010_0000, '0);
    chk("busy_set", busy, 1);
    xact(0, 1, '0, 32'h0010_0000, '0);
    finish_pulse();
    xact(1, 0, 32'h000F_000C, '0, '0);
    xact(1, 0, 32'h000F_000C, '0, '0);

    sp_delay = 2;
    xact(1, 1, 32'h0000_0008, 32'h0000_000C, 32'h77);
    xact(1, 1, 32'h0000_0004, 32'h000F_0008, 32'h88);

    xact(1, 0, 32'h0020_0000, '0, '0);
    xact(0, 1, '0, 32'h0010_0000, '0);
    xact(0, 1, '0, 32'h000F_0000, 32'h5555);
    finish_pulse();
    finish_pulse();

    for (int n = 0; n < 200; n++) begin
      sp_delay = $urandom_range(0, 4);
      op = $urandom_range(0, 9);
      a = gen_addr();
      b = gen_addr();
      if (op < 3) xact(1, 0, a, '0, '0);
      else if (op < 6) xact(0, 1, '0, b, $urandom);
      else if (op < 8) xact(1, 1, a, b, $urandom);
      else finish_pulse();
    end

    if (!m_busy) xact(0, 1, '0, 32'h0010_0000, '0);
    sp_delay = 20;
    @(negedge clk);
    arvalid = 1'b1;
    araddr = 32'h0000_0020;
    #1 chk("rst_case_arready", arready, 1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sp_rd_pending", sc_read_en, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("sc_rd_async_rst", sc_read_en, 0);
    chk("rvalid_async_rst", rvalid, 0);
    chk("start_async_rst", start_matmul, 0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_rvalid_after_rst", rvalid, 0);
    end
    check_regs();
    sp_delay = 1;
    xact(1, 0, 32'h0000_0020, '0, '0);
    xact(1, 1, 32'h0000_0024, 32'h000F_0000, 32'h99);

    chk("sc_both_en", both_cnt, 0);
    chk("sc_stable", sp_unstable, 0);
    chk("start_width", start_hi, m_pulses);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
